core_fetch_queue: RTL

- Instruction-fetch front end for the 5-stage MIPS64 core; produces the pc/pc4/inst bundle that the decode stage consumes.
- Issues in-order word fetches to instruction memory over a request/grant/response interface with variable latency.
- Buffers returned instructions in a small FIFO, so a decode stall does not stop memory traffic.
- Handles redirects from branches, jumps, exceptions and ERET by discarding queued and in-flight fetches.

---
 rtl/core_fetch_queue.sv | 111 +++++++++++
 1 files changed

// File: rtl/core_fetch_queue.sv
// core_fetch_queue: in-order instruction fetch front end with response FIFO and redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating starvation and redirect counters.
module core_fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc4,
  output logic [31:0] out_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_starve_cycles,
  output logic [31:0] perf_redirects
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  logic [63:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight, drop_cnt;
  logic [AW-1:0] head, tail;
  logic [SW-1:0] s_head, s_tail;
  logic [63:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic [63:0]   s_pc   [MAX_OUTSTANDING];
  logic [63:0]   target;
  logic          gnt, rsp, push, pop;
  int            free;
  function automatic logic [SW-1:0] s_inc(input logic [SW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  // Live in-flight responses already own a FIFO slot; dropped ones do not.
  always_comb begin
    free      = DEPTH - int'(count) - (int'(inflight) - int'(drop_cnt));
    imem_req  = reset && !redirect_valid && free > 0 && int'(inflight) < MAX_OUTSTANDING;
    imem_addr = fetch_pc;
    target    = redirect_pc & ~64'd3;
    gnt       = imem_req && imem_gnt;
    rsp       = imem_rvalid && inflight != '0;
    push      = rsp && !redirect_valid && drop_cnt == '0;
    out_valid = count != '0;
    pop       = out_valid && !stall && !redirect_valid;
    out_pc    = out_valid ? q_pc[head] : '0;
    out_pc4   = out_valid ? q_pc[head] + 64'd4 : '0;
    out_inst  = out_valid ? q_inst[head] : '0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      head     <= '0;
      tail     <= '0;
      s_head   <= '0;
      s_tail   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= inflight - IW'(rsp);
      drop_cnt <= inflight - IW'(rsp);
      if (rsp) s_head <= s_inc(s_head);
    end else begin
      if (gnt) fetch_pc <= fetch_pc + 64'd4;
      inflight <= inflight + IW'(gnt) - IW'(rsp);
      if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (gnt) s_tail <= s_inc(s_tail);
      if (rsp) s_head <= s_inc(s_head);
    end
  end
  // Storage needs no reset: every read is gated by count or inflight.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[tail]   <= s_pc[s_head];
      q_inst[tail] <= imem_rdata;
    end
    if (gnt) s_pc[s_tail] <= fetch_pc;
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_starve_cycles <= '0;
      perf_redirects     <= '0;
    end else begin
      if (!out_valid && !redirect_valid && perf_starve_cycles != '1)
        perf_starve_cycles <= perf_starve_cycles + 1'b1;
      if (redirect_valid && perf_redirects != '1)
        perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif
endmodule
